alu_sequencer: RTL
==================

# alu_sequencer

Front-panel controller that sequences the ALU datapath on the DE-series board. It collects operand A, operand B and an opcode from the slide switches, using the pushbuttons to step through entry. It then issues a one-cycle start to the ALU, waits for its done handshake (with a timeout), and holds the result for the HEX displays and LEDs. It sits between the board I/O in `top` and the ALU instance, and replaces direct switch-to-ALU wiring.

## Interface
- `WIDTH`, 8: operand width; the result is 2*WIDTH.
- `DEBOUNCE_CYCLES`, 250000: stable-level cycles a key needs before it is accepted (5 ms at 50 MHz; benches use 4).
- `TIMEOUT_CYCLES`, 1024: maximum cycles spent in S_WAIT before an error is raised.
- `CLOCK_50`  in  1: the only clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `KEY`  in  2: raw active-low pushbuttons. KEY[0] is enter; KEY[1] is cancel.
- `SW`  in  WIDTH: operand and opcode entry. The opcode is SW[3:0].
- `alu_a`, `alu_b`  out  WIDTH: registered operands to the ALU.
- `alu_op`  out  4: registered opcode.
- `alu_start`  out  1: one-cycle start pulse.
- `alu_done`  in  1: ALU completion pulse. Sampled only in S_WAIT.
- `alu_result`  in  2*WIDTH: valid in the cycle `alu_done` is high.
- `disp`  out  3*WIDTH: nibble stream for the HEX decoders.
- `led`  out  10: status lights for LEDR.

## Operation
- Each key passes through a 2-FF synchronizer and a debouncer. A debounced high-to-low transition produces one `enter` or `cancel` pulse, lasting one cycle. Holding a key produces no repeat pulses.
- States, one-hot: S_A, S_B, S_OP, S_RUN, S_WAIT, S_SHOW, S_ERR. Reset enters S_A.
- S_A, on enter: a_reg <= SW, go to S_B.
- S_B, on enter: b_reg <= SW, go to S_OP.
- S_OP, on enter: op_reg <= SW[3:0], go to S_RUN.
- S_RUN: `alu_start`=1 for exactly one cycle, clear the timeout counter, go to S_WAIT.
- S_WAIT:
  - If `alu_done`: res_reg <= `alu_result`, go to S_SHOW.
  - Else, when the counter reaches TIMEOUT_CYCLES-1: set err, go to S_ERR.
  - Otherwise increment the counter.
- S_SHOW, on enter: go to S_RUN. This re-executes the operation with the same operands.
- S_ERR, on enter: go to S_A.
- Cancel in any state goes to S_A and clears a_reg, b_reg, op_reg, res_reg, err and the counter.
  - Cancel has priority over enter and over `alu_done` arriving in the same cycle.
- `alu_done` outside S_WAIT is ignored. A late done after a cancel or timeout has no effect.
- `alu_a`/`alu_b`/`alu_op` are driven continuously from a_reg/b_reg/op_reg and remain stable from S_RUN until the next entry.
- `disp`:
  - In S_A/S_B/S_OP: {a_reg, b_reg, op_reg zero-extended to WIDTH}.
  - In S_RUN/S_WAIT/S_SHOW: {op_reg zero-extended, res_reg}.
  - In S_ERR: all ones.
- `led`:
  - led[6:0] is the one-hot state.
  - led[8] is busy (S_RUN or S_WAIT).
  - led[9] is err.
  - led[7] is 0.

## Timing
- Reset values:
  - all registers 0.
  - `alu_start`=0.
  - `disp`=0.
  - `led`=10'b0000000001 (S_A).
  - Debouncers report the released state.
- Key latency: press to state change = 2 (sync) + DEBOUNCE_CYCLES + 1 (edge) cycles.
- `alu_start` rises one cycle after the enter pulse in S_OP.
- The earliest accepted `alu_done` is the cycle after `alu_start`.
- res_reg and `disp` update one cycle after `alu_done`.
- Timeout: S_ERR is entered after exactly TIMEOUT_CYCLES cycles in S_WAIT without done.
- Reset asserted mid-operation forces S_A immediately (asynchronous). `alu_start` drops in the same instant.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- `alu_pkg`:
  - state encoding constants.
  - 4-bit opcode constants shared with the ALU (OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4, OP_MUL=5).
  - display-blank constant.
- Sub-module `key_debounce`, parameterized by DEBOUNCE_CYCLES. It contains the synchronizer, stable counter and falling-edge pulse, and is instanced once per key.
- The FSM, the registers and the output muxing stay in `alu_sequencer`.

## Test plan
- **Normal entry.** Reset, then enter SW=8'h12, 8'h34, 4'h0. Required: `alu_a`=12, `alu_b`=34, `alu_op`=0, and a single-cycle `alu_start`. The model returns done with 16'h0046 after 3 cycles. Required: `disp`=24'h000046, led[5]=1.
- **Re-run from S_SHOW.** Press enter in S_SHOW. Required: a second `alu_start` with unchanged operands. Then change the model result to 16'h0099 and check that `disp` follows.
- **Timeout.** The model never asserts done. Required: led[9]=1 and `disp`=24'hFFFFFF exactly 1024 cycles after S_WAIT entry. A later enter returns to S_A.
- **Cancel during S_WAIT.** Assert cancel and `alu_done` in the same cycle. Required: state S_A, res_reg=0, `disp`=0. A later done is ignored.
- **Debounce.** Bounce KEY[0] every 2 cycles for 20 cycles, then hold it low. Required: exactly one enter pulse. A 3-cycle glitch is rejected.
- **Reset mid-run.** Pulse reset during S_WAIT. Required: all outputs at their reset values in the same cycle, led=10'b0000000001.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Brief    : State encoding, ALU opcodes and display constants for the
//            front-panel ALU sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int ST_W = 7;

    localparam int IDX_A    = 0;
    localparam int IDX_B    = 1;
    localparam int IDX_OP   = 2;
    localparam int IDX_RUN  = 3;
    localparam int IDX_WAIT = 4;
    localparam int IDX_SHOW = 5;
    localparam int IDX_ERR  = 6;

    localparam logic [ST_W-1:0] S_A    = 7'b000_0001;
    localparam logic [ST_W-1:0] S_B    = 7'b000_0010;
    localparam logic [ST_W-1:0] S_OP   = 7'b000_0100;
    localparam logic [ST_W-1:0] S_RUN  = 7'b000_1000;
    localparam logic [ST_W-1:0] S_WAIT = 7'b001_0000;
    localparam logic [ST_W-1:0] S_SHOW = 7'b010_0000;
    localparam logic [ST_W-1:0] S_ERR  = 7'b100_0000;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_MUL = 4'd5;

    // Fill bit replicated across the whole display while in the error state.
    localparam logic DISP_BLANK = 1'b1;

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// Module   : key_debounce
// Brief    : 2-FF synchronizer, stable-level debouncer and one-cycle
//            falling-edge pulse for one active-low pushbutton.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_fall
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;
    logic             w_settled;

    assign w_settled = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign o_fall    = r_fall;

    // Released (high) is the reset level so no pulse fires out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_stable <= 1'b1;
            r_cnt    <= '0;
            r_fall   <= 1'b0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            r_fall  <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (w_settled) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
                r_fall   <= r_stable;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// Module   : alu_sequencer
// Brief    : Front-panel controller: switch/key operand entry, ALU start/done
//            handshake with timeout, result hold for HEX displays and LEDs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic [1:0]           KEY,
    input  logic [WIDTH-1:0]     SW,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [3:0]           alu_op,
    output logic                 alu_start,
    input  logic                 alu_done,
    input  logic [2*WIDTH-1:0]   alu_result,
    output logic [3*WIDTH-1:0]   disp,
    output logic [9:0]           led
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [1:0]         w_fall;
    logic               w_enter;
    logic               w_cancel;

    logic [ST_W-1:0]    r_state,  w_state_nxt;
    logic [WIDTH-1:0]   r_a,      w_a_nxt;
    logic [WIDTH-1:0]   r_b,      w_b_nxt;
    logic [3:0]         r_op,     w_op_nxt;
    logic [2*WIDTH-1:0] r_res,    w_res_nxt;
    logic               r_err,    w_err_nxt;
    logic [CNT_W-1:0]   r_cnt,    w_cnt_nxt;
    logic [WIDTH-1:0]   w_op_ext;

    generate
        for (genvar k = 0; k < 2; k++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_key_debounce (
                .clk     (CLOCK_50),
                .rst     (reset),
                .i_key_n (KEY[k]),
                .o_fall  (w_fall[k])
            );
        end
    endgenerate

    assign w_enter  = w_fall[0];
    assign w_cancel = w_fall[1];

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= S_A;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_res   <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_op    <= w_op_nxt;
            r_res   <= w_res_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Cancel outranks enter and a same-cycle done; done is only seen in S_WAIT.
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_op_nxt    = r_op;
        w_res_nxt   = r_res;
        w_err_nxt   = r_err;
        w_cnt_nxt   = r_cnt;
        if (w_cancel) begin
            w_state_nxt = S_A;
            w_a_nxt     = '0;
            w_b_nxt     = '0;
            w_op_nxt    = '0;
            w_res_nxt   = '0;
            w_err_nxt   = 1'b0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_A: if (w_enter) begin
                    w_a_nxt     = SW;
                    w_state_nxt = S_B;
                end
                S_B: if (w_enter) begin
                    w_b_nxt     = SW;
                    w_state_nxt = S_OP;
                end
                S_OP: if (w_enter) begin
                    w_op_nxt    = SW[3:0];
                    w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (alu_done) begin
                        w_res_nxt   = alu_result;
                        w_state_nxt = S_SHOW;
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_ERR;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_SHOW: if (w_enter) w_state_nxt = S_RUN;
                S_ERR:  if (w_enter) w_state_nxt = S_A;
                default: w_state_nxt = S_A;
            endcase
        end
    end

    // Outputs decode flops only; no input reaches an output combinationally.
    assign w_op_ext  = {{(WIDTH-4){1'b0}}, r_op};
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_op    = r_op;
    assign alu_start = r_state[IDX_RUN];
    assign led       = {r_err, r_state[IDX_RUN] | r_state[IDX_WAIT], 1'b0, r_state};

    always_comb begin
        disp = {r_a, r_b, w_op_ext};
        if (r_state[IDX_ERR])
            disp = {(3*WIDTH){DISP_BLANK}};
        else if (r_state[IDX_RUN] | r_state[IDX_WAIT] | r_state[IDX_SHOW])
            disp = {w_op_ext, r_res};
    end

endmodule

`default_nettype wire
